// File: rtl/snake_game_ctrl_if.sv
// Bundle between the snake game sequencer and its neighbours:
// the key debouncers, the body/head datapath and the apple generator.
interface snake_game_ctrl_if #(
    parameter int SCORE_W = 10
);
    logic               key_start;
    logic [3:0]         key_dir;
    logic [5:0]         head_x;
    logic [5:0]         head_y;
    logic               body_hit;
    logic               apple_hit;
    logic               apple_ack;
    logic               move_en;
    logic [1:0]         dir;
    logic               grow;
    logic               apple_req;
    logic               snake_rst;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;

    modport master (
        input  key_start, key_dir, head_x, head_y, body_hit, apple_hit, apple_ack,
        output move_en, dir, grow, apple_req, snake_rst, game_state, score
    );

    modport slave (
        output key_start, key_dir, head_x, head_y, body_hit, apple_hit, apple_ack,
        input  move_en, dir, grow, apple_req, snake_rst, game_state, score
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: step timer, direction commit, collision/apple checks,
// growth, scoring and apple respawn handshake. All outputs are registered.
module snake_game_ctrl #(
    parameter int TICK_DIV = 12_500_000,
    parameter int X_MAX    = 39,
    parameter int Y_MAX    = 29,
    parameter int SCORE_W  = 10
) (
    input logic               CLK_50M,
    input logic               RST,
    snake_game_ctrl_if.master bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_MOVE    = 3'd3,
        S_CHECK   = 3'd4,
        S_RESPAWN = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic [TICK_W-1:0]  tick_r;
    logic [1:0]         dir_r;
    logic [1:0]         pending_r;
    logic [SCORE_W-1:0] score_r;
    logic               move_en_r;
    logic               grow_r;
    logic               apple_req_r;
    logic               snake_rst_r;
    logic [1:0]         game_state_r;

    logic               tick_done_s;
    logic               collide_s;
    logic               eat_s;
    logic [1:0]         key_code_s;
    logic               key_valid_s;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // key_dir is {up,down,left,right}; dir codes are up 00, down 01, left 10, right 11
    function automatic logic [1:0] key_to_dir(input logic [3:0] v);
        logic [1:0] d;
        case (v)
            4'b1000: d = 2'b00;
            4'b0100: d = 2'b01;
            4'b0010: d = 2'b10;
            default: d = 2'b11;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] state_code(input state_t s);
        logic [1:0] c;
        case (s)
            S_IDLE:    c = 2'b00;
            S_OVER:    c = 2'b10;
            S_INIT, S_RUN, S_MOVE, S_CHECK, S_RESPAWN: c = 2'b01;
            default:   c = 2'b00;
        endcase
        return c;
    endfunction

    assign tick_done_s = (tick_r == TICK_W'(TICK_DIV - 1));
    assign collide_s   = (bus.head_x == 6'd0) || (bus.head_x == 6'(X_MAX)) ||
                         (bus.head_y == 6'd0) || (bus.head_y == 6'(Y_MAX)) || bus.body_hit;
    assign eat_s       = (state_r == S_CHECK) && !collide_s && bus.apple_hit;
    assign key_code_s  = key_to_dir(bus.key_dir);
    // Reversal flips the low bit of the code: up<->down, left<->right
    assign key_valid_s = is_onehot4(bus.key_dir) &&
                         (key_code_s != {dir_r[1], ~dir_r[0]}) &&
                         (state_r != S_IDLE) && (state_r != S_OVER);

    // State register
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.key_start) next_s = S_INIT;
                else               next_s = S_IDLE;
            end
            S_INIT:  next_s = S_RUN;
            S_RUN: begin
                if (tick_done_s) next_s = S_MOVE;
                else             next_s = S_RUN;
            end
            S_MOVE:  next_s = S_CHECK;
            S_CHECK: begin
                if (collide_s)          next_s = S_OVER;
                else if (bus.apple_hit) next_s = S_RESPAWN;
                else                    next_s = S_RUN;
            end
            S_RESPAWN: begin
                if (bus.apple_ack) next_s = S_RUN;
                else               next_s = S_RESPAWN;
            end
            S_OVER: begin
                if (bus.key_start) next_s = S_INIT;
                else               next_s = S_OVER;
            end
            default: next_s = S_IDLE;
        endcase
    end

    // Step timer, direction commit and score; cleared on entry to INIT so they read clean during INIT
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            tick_r    <= '0;
            dir_r     <= 2'b11;
            pending_r <= 2'b11;
            score_r   <= '0;
        end else if (next_s == S_INIT) begin
            tick_r    <= '0;
            dir_r     <= 2'b11;
            pending_r <= 2'b11;
            score_r   <= '0;
        end else begin
            if (state_r == S_RUN) begin
                tick_r <= tick_done_s ? '0 : tick_r + TICK_W'(1);
            end else begin
                tick_r <= tick_r;
            end
            if (key_valid_s) begin
                pending_r <= key_code_s;
            end else begin
                pending_r <= pending_r;
            end
            // dir is committed on entry to MOVE so the datapath sees it with move_en
            if (next_s == S_MOVE) begin
                dir_r <= pending_r;
            end else begin
                dir_r <= dir_r;
            end
            if (eat_s && (score_r != {SCORE_W{1'b1}})) begin
                score_r <= score_r + SCORE_W'(1);
            end else begin
                score_r <= score_r;
            end
        end
    end

    // Registered pulse/level outputs derived from the upcoming state
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            move_en_r    <= 1'b0;
            grow_r       <= 1'b0;
            apple_req_r  <= 1'b0;
            snake_rst_r  <= 1'b0;
            game_state_r <= 2'b00;
        end else begin
            move_en_r    <= (next_s == S_MOVE);
            grow_r       <= eat_s;
            apple_req_r  <= (next_s == S_RESPAWN);
            snake_rst_r  <= (next_s == S_INIT);
            game_state_r <= state_code(next_s);
        end
    end

    assign bus.move_en    = move_en_r;
    assign bus.dir        = dir_r;
    assign bus.grow       = grow_r;
    assign bus.apple_req  = apple_req_r;
    assign bus.snake_rst  = snake_rst_r;
    assign bus.game_state = game_state_r;
    assign bus.score      = score_r;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Table-driven bench for snake_game_ctrl with TICK_DIV=4 and SCORE_W=2,
// plus hand-written sequences for saturation, reset in RESPAWN and body collision.
module tb_snake_game_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    snake_game_ctrl_if #(.SCORE_W(2)) bus ();

    snake_game_ctrl #(
        .TICK_DIV(4),
        .X_MAX   (39),
        .Y_MAX   (29),
        .SCORE_W (2)
    ) dut (
        .CLK_50M(clk),
        .RST    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ks;
        logic [3:0] kd;
        logic [5:0] hx;
        logic [5:0] hy;
        logic       bh;
        logic       ah;
        logic       ack;
        logic       e_mv;
        logic [1:0] e_dir;
        logic       e_gr;
        logic       e_rq;
        logic       e_sr;
        logic [1:0] e_gs;
        logic [1:0] e_sc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic ks, input logic [3:0] kd,
                       input logic [5:0] hx, input logic [5:0] hy,
                       input logic bh, input logic ah, input logic ack,
                       input logic mv, input logic [1:0] d, input logic gr,
                       input logic rq, input logic sr, input logic [1:0] gs,
                       input logic [1:0] sc);
        vec_t v;
        v.rst = r; v.ks = ks; v.kd = kd; v.hx = hx; v.hy = hy;
        v.bh = bh; v.ah = ah; v.ack = ack;
        v.e_mv = mv; v.e_dir = d; v.e_gr = gr; v.e_rq = rq;
        v.e_sr = sr; v.e_gs = gs; v.e_sc = sc;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        bus.key_start = 1'b0;
        bus.key_dir   = 4'd0;
        bus.head_x    = 6'd10;
        bus.head_y    = 6'd10;
        bus.body_hit  = 1'b0;
        bus.apple_hit = 1'b0;
        bus.apple_ack = 1'b0;
    endtask

    task automatic wait_move(input string name);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            found = bus.move_en;
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] act;
        logic [9:0] exp;
        logic [1:0] exp_sc;
        n_vec = 0;
        n_err = 0;
        idle_inputs();

        //   rst ks kd      hx     hy     bh ah ack | mv dir  gr rq sr gs     sc
        add(1, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd0, 2'd0); // reset
        add(0, 0, 4'b0010, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd0, 2'd0); // key ignored in IDLE
        add(0, 1, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 1, 2'd1, 2'd0); // INIT
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0); // RUN t0
        add(0, 1, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0); // start ignored
        add(0, 0, 4'b0010, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0); // left = reverse
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   1, 2'd3, 0, 0, 0, 2'd1, 2'd0); // first MOVE
        add(0, 0, 4'b1000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0); // up during MOVE
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0); // CHECK clear
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   1, 2'd0, 0, 0, 0, 2'd1, 2'd0); // MOVE, dir up
        add(0, 0, 4'b0100, 6'd10, 6'd10, 0, 0, 0,   0, 2'd0, 0, 0, 0, 2'd1, 2'd0); // down = reverse
        add(0, 0, 4'b0011, 6'd10, 6'd10, 0, 1, 0,   0, 2'd0, 1, 1, 0, 2'd1, 2'd1); // apple
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd0, 0, 1, 0, 2'd1, 2'd1);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd0, 0, 1, 0, 2'd1, 2'd1);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 1,   0, 2'd0, 0, 0, 0, 2'd1, 2'd1); // ack
        add(0, 0, 4'b0010, 6'd10, 6'd10, 0, 0, 0,   0, 2'd0, 0, 0, 0, 2'd1, 2'd1); // left accepted
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd0, 0, 0, 0, 2'd1, 2'd1);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd0, 0, 0, 0, 2'd1, 2'd1);
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   1, 2'd2, 0, 0, 0, 2'd1, 2'd1); // MOVE, dir left
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd2, 0, 0, 0, 2'd1, 2'd1);
        add(0, 0, 4'b0000, 6'd39, 6'd10, 0, 1, 0,   0, 2'd2, 0, 0, 0, 2'd2, 2'd1); // wall beats apple
        add(0, 0, 4'b0001, 6'd10, 6'd10, 0, 0, 0,   0, 2'd2, 0, 0, 0, 2'd2, 2'd1); // OVER holds
        add(0, 1, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 1, 2'd1, 2'd0); // restart
        add(0, 0, 4'b0000, 6'd10, 6'd10, 0, 0, 0,   0, 2'd3, 0, 0, 0, 2'd1, 2'd0); // RUN t0

        for (int i = 0; i < tbl.size(); i++) begin
            rst           = tbl[i].rst;
            bus.key_start = tbl[i].ks;
            bus.key_dir   = tbl[i].kd;
            bus.head_x    = tbl[i].hx;
            bus.head_y    = tbl[i].hy;
            bus.body_hit  = tbl[i].bh;
            bus.apple_hit = tbl[i].ah;
            bus.apple_ack = tbl[i].ack;
            step();
            act = {bus.move_en, bus.dir, bus.grow, bus.apple_req, bus.snake_rst,
                   bus.game_state, bus.score};
            exp = {tbl[i].e_mv, tbl[i].e_dir, tbl[i].e_gr, tbl[i].e_rq, tbl[i].e_sr,
                   tbl[i].e_gs, tbl[i].e_sc};
            chk($sformatf("vec%0d", i), {22'd0, act}, {22'd0, exp});
        end
        idle_inputs();

        // Four apples in a row with a 2-bit score; ack already high on entry to RESPAWN
        for (int k = 0; k < 4; k++) begin
            wait_move($sformatf("sat_move%0d", k));
            step();
            bus.apple_hit = 1'b1;
            bus.apple_ack = (k != 3);
            step();
            bus.apple_hit = 1'b0;
            exp_sc = (k >= 2) ? 2'd3 : 2'(k + 1);
            chk($sformatf("sat_grow%0d", k), {31'd0, bus.grow}, 32'd1);
            chk($sformatf("sat_req%0d", k), {31'd0, bus.apple_req}, 32'd1);
            chk($sformatf("sat_score%0d", k), {30'd0, bus.score}, {30'd0, exp_sc});
            if (k != 3) begin
                step();
                bus.apple_ack = 1'b0;
                chk($sformatf("sat_reqdrop%0d", k), {31'd0, bus.apple_req}, 32'd0);
            end
        end

        // Request held without ack, then reset in RESPAWN
        step();
        chk("req_hold", {31'd0, bus.apple_req}, 32'd1);
        chk("grow_pulse", {31'd0, bus.grow}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req", {31'd0, bus.apple_req}, 32'd0);
        chk("rst_state", {30'd0, bus.game_state}, 32'd0);
        chk("rst_score", {30'd0, bus.score}, 32'd0);
        chk("rst_dir", {30'd0, bus.dir}, 32'd3);

        // Body collision ends the game without scoring
        bus.key_start = 1'b1;
        step();
        bus.key_start = 1'b0;
        chk("body_srst", {31'd0, bus.snake_rst}, 32'd1);
        wait_move("body_move");
        step();
        bus.body_hit  = 1'b1;
        bus.apple_hit = 1'b1;
        step();
        bus.body_hit  = 1'b0;
        bus.apple_hit = 1'b0;
        chk("body_over", {30'd0, bus.game_state}, 32'd2);
        chk("body_grow", {31'd0, bus.grow}, 32'd0);
        chk("body_score", {30'd0, bus.score}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
